// File: rtl/sdram_arbiter.sv
// Two-client arbiter in front of the single SDRAM controller read/write port.
// Latches one client's command, drives the controller, returns fin/rdata to that client.
module sdram_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_fin,

    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_fin,
    output logic [DATA_W-1:0] c0_rdata,

    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_fin,
    output logic [DATA_W-1:0] c1_rdata,

    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_fin,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_wr_fin,

    output logic              busy,
    output logic              grant_id
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              grant_id_q, grant_id_d;
    logic              last_grant_q, last_grant_d;
    logic              c0_fin_q, c0_fin_d;
    logic              c1_fin_q, c1_fin_d;
    logic [DATA_W-1:0] c0_rdata_q, c0_rdata_d;
    logic [DATA_W-1:0] c1_rdata_q, c1_rdata_d;
    logic              rd_req_q, rd_req_d;
    logic              wr_req_q, wr_req_d;

    logic pend0, pend1, sel, mem_fin;

    always_comb begin
        pend0   = c0_req & ~c0_fin_q;
        pend1   = c1_req & ~c1_fin_q;
        mem_fin = we_q ? mem_wr_fin : mem_rd_fin;

        if (pend0 && pend1)
            sel = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
        else
            sel = pend1;

        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        c0_rdata_d   = c0_rdata_q;
        c1_rdata_d   = c1_rdata_q;
        rd_req_d     = rd_req_q;
        wr_req_d     = wr_req_q;
        // fin holds only while the client keeps req high
        c0_fin_d     = c0_fin_q & c0_req;
        c1_fin_d     = c1_fin_q & c1_req;

        case (state_q)
            S_IDLE: begin
                if (init_fin && (pend0 || pend1)) begin
                    grant_id_d   = sel;
                    last_grant_d = sel;
                    we_d         = sel ? c1_we    : c0_we;
                    addr_d       = sel ? c1_addr  : c0_addr;
                    wdata_d      = sel ? c1_wdata : c0_wdata;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!init_fin) begin
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                    state_d  = S_IDLE;
                end else if ((rd_req_q || wr_req_q) && mem_fin) begin
                    if (!we_q) begin
                        if (grant_id_q) c1_rdata_d = mem_rd_data;
                        else            c0_rdata_d = mem_rd_data;
                    end
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                    state_d  = S_RELEASE;
                end else begin
                    rd_req_d = ~we_q;
                    wr_req_d = we_q;
                end
            end
            S_RELEASE: begin
                if (!init_fin) begin
                    state_d = S_IDLE;
                end else if (!mem_fin) begin
                    if (grant_id_q) c1_fin_d = 1'b1;
                    else            c0_fin_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                rd_req_d = 1'b0;
                wr_req_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
            c0_fin_q     <= 1'b0;
            c1_fin_q     <= 1'b0;
            c0_rdata_q   <= '0;
            c1_rdata_q   <= '0;
            rd_req_q     <= 1'b0;
            wr_req_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            c0_fin_q     <= c0_fin_d;
            c1_fin_q     <= c1_fin_d;
            c0_rdata_q   <= c0_rdata_d;
            c1_rdata_q   <= c1_rdata_d;
            rd_req_q     <= rd_req_d;
            wr_req_q     <= wr_req_d;
        end
    end

    assign c0_fin      = c0_fin_q;
    assign c1_fin      = c1_fin_q;
    assign c0_rdata    = c0_rdata_q;
    assign c1_rdata    = c1_rdata_q;
    assign mem_rd_req  = rd_req_q;
    assign mem_wr_req  = wr_req_q;
    assign mem_rd_addr = addr_q;
    assign mem_wr_addr = addr_q;
    assign mem_wr_data = wdata_q;
    assign busy        = (state_q != S_IDLE);
    assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: instance 0 round-robin, instance 1 fixed priority,
// each behind a behavioural SDRAM controller with a sparse memory.
module tb_sdram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      [2];
    logic        init_fin [2];
    logic        c_req    [2][2];
    logic        c_we     [2][2];
    logic [31:0] c_addr   [2][2];
    logic [31:0] c_wdata  [2][2];
    logic        c_fin    [2][2];
    logic [31:0] c_rdata  [2][2];
    logic        m_rd_req [2], m_wr_req [2], m_rd_fin [2], m_wr_fin [2];
    logic [31:0] m_rd_addr[2], m_wr_addr[2], m_wr_data[2], m_rd_data[2];
    logic        busy     [2], gid [2];

    // controller model state
    logic        m_fin [2], m_we [2];
    int          cnt [2], rnd [2], force_dly [2];

    typedef struct { int inst; logic we; logic [31:0] addr; logic [31:0] data; } ent_t;
    ent_t        log_q[$];
    logic [31:0] mem     [logic [32:0]];
    logic [31:0] ref_mem [logic [32:0]];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sdram_arbiter #(.FIXED_PRIO(g), .ADDR_W(32), .DATA_W(32)) dut (
            .clk(clk), .reset(rst[g]), .init_fin(init_fin[g]),
            .c0_req(c_req[g][0]), .c0_we(c_we[g][0]), .c0_addr(c_addr[g][0]),
            .c0_wdata(c_wdata[g][0]), .c0_fin(c_fin[g][0]), .c0_rdata(c_rdata[g][0]),
            .c1_req(c_req[g][1]), .c1_we(c_we[g][1]), .c1_addr(c_addr[g][1]),
            .c1_wdata(c_wdata[g][1]), .c1_fin(c_fin[g][1]), .c1_rdata(c_rdata[g][1]),
            .mem_rd_req(m_rd_req[g]), .mem_rd_addr(m_rd_addr[g]), .mem_rd_fin(m_rd_fin[g]),
            .mem_rd_data(m_rd_data[g]), .mem_wr_req(m_wr_req[g]), .mem_wr_addr(m_wr_addr[g]),
            .mem_wr_data(m_wr_data[g]), .mem_wr_fin(m_wr_fin[g]),
            .busy(busy[g]), .grant_id(gid[g])
        );
        assign m_rd_fin[g] = m_fin[g] & ~m_we[g];
        assign m_wr_fin[g] = m_fin[g] &  m_we[g];
    end

    function automatic logic [32:0] key(int i, logic [31:0] a);
        logic [31:0] iv;
        iv = i;
        return {iv[0], a};
    endfunction

    function automatic logic [31:0] dflt(logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Controller: fin some cycles after req, held until req drops, then cleared.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("mem_req_exclusive", 64'(m_rd_req[i] & m_wr_req[i]), 64'd0);
            if (!(m_rd_req[i] || m_wr_req[i])) begin
                cnt[i]   <= 0;
                rnd[i]   <= $urandom_range(1, 4);
                m_fin[i] <= 1'b0;
            end else if (!m_fin[i]) begin
                if (cnt[i] + 1 >= ((force_dly[i] > 0) ? force_dly[i] : rnd[i])) begin
                    m_fin[i] <= 1'b1;
                    m_we[i]  <= m_wr_req[i];
                    if (m_wr_req[i]) begin
                        mem[key(i, m_wr_addr[i])] = m_wr_data[i];
                        log_q.push_back('{i, 1'b1, m_wr_addr[i], m_wr_data[i]});
                    end else begin
                        m_rd_data[i] <= mem.exists(key(i, m_rd_addr[i])) ?
                                        mem[key(i, m_rd_addr[i])] : dflt(m_rd_addr[i]);
                        log_q.push_back('{i, 1'b0, m_rd_addr[i], 32'h0});
                    end
                end else begin
                    cnt[i] <= cnt[i] + 1;
                end
            end
        end
    end

    task automatic wait_fin(int i, int c, output bit got);
        got = 1'b0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            got = c_fin[i][c];
        end
        chk("fin_timeout", 64'(got), 64'd1);
    endtask

    // One client transaction with full handshake; read data checked against ref_mem.
    task automatic txn(int i, int c, logic we, logic [31:0] addr, logic [31:0] wd);
        bit got;
        logic [31:0] exp;
        @(negedge clk);
        c_we[i][c] = we; c_addr[i][c] = addr; c_wdata[i][c] = wd; c_req[i][c] = 1'b1;
        wait_fin(i, c, got);
        if (got) begin
            chk("grant_id_at_fin", 64'(gid[i]), 64'(c));
            if (we) begin
                ref_mem[key(i, addr)] = wd;
            end else begin
                exp = ref_mem.exists(key(i, addr)) ? ref_mem[key(i, addr)] : dflt(addr);
                chk("rdata", 64'(c_rdata[i][c]), 64'(exp));
            end
        end
        c_req[i][c] = 1'b0;
        @(negedge clk);
        chk("fin_clears", 64'(c_fin[i][c]), 64'd0);
    endtask

    task automatic rand_client(int i, int c);
        logic        we;
        logic [31:0] a, wd;
        for (int k = 0; k < 6; k++) begin
            we = 1'($urandom_range(0, 1));
            a  = (c == 1 ? 32'h2000 : 32'h1000) + 32'($urandom_range(0, 3) * 4);
            wd = $urandom;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            txn(i, c, we, a, wd);
        end
    endtask

    task automatic do_reset(int i);
        c_req[i][0] = 1'b0; c_req[i][1] = 1'b0;
        rst[i] = 1'b1;
        repeat (2) @(negedge clk);
        rst[i] = 1'b0;
    endtask

    initial begin
        bit          got, seen;
        int          pulses;
        logic [31:0] w;

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; init_fin[i] = 1'b1; force_dly[i] = 0;
            m_fin[i] = 1'b0; m_we[i] = 1'b0; m_rd_data[i] = '0; cnt[i] = 0; rnd[i] = 1;
            for (int c = 0; c < 2; c++) begin
                c_req[i][c] = 1'b0; c_we[i][c] = 1'b0; c_addr[i][c] = '0; c_wdata[i][c] = '0;
            end
        end
        repeat (3) @(negedge clk);

        // reset state
        for (int i = 0; i < 2; i++) begin
            chk("rst_rd_req", 64'(m_rd_req[i]), 64'd0);
            chk("rst_wr_req", 64'(m_wr_req[i]), 64'd0);
            chk("rst_busy",   64'(busy[i]), 64'd0);
            chk("rst_gid",    64'(gid[i]), 64'd0);
            chk("rst_wdata",  64'(m_wr_data[i]), 64'd0);
            chk("rst_addr",   64'(m_rd_addr[i]), 64'd0);
            for (int c = 0; c < 2; c++) begin
                chk("rst_fin",   64'(c_fin[i][c]), 64'd0);
                chk("rst_rdata", 64'(c_rdata[i][c]), 64'd0);
            end
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);

        // single read with one-cycle issue latency
        mem[key(0, 32'h400)] = 32'hDEAD_BEEF;
        ref_mem[key(0, 32'h400)] = 32'hDEAD_BEEF;
        force_dly[0] = 5;
        c_we[0][0] = 1'b0; c_addr[0][0] = 32'h400; c_req[0][0] = 1'b1;
        @(negedge clk);
        chk("s1_busy", 64'(busy[0]), 64'd1);
        chk("s1_rd_req_early", 64'(m_rd_req[0]), 64'd0);
        @(negedge clk);
        chk("s1_rd_req", 64'(m_rd_req[0]), 64'd1);
        chk("s1_wr_req", 64'(m_wr_req[0]), 64'd0);
        chk("s1_rd_addr", 64'(m_rd_addr[0]), 64'h400);
        wait_fin(0, 0, got);
        chk("s1_rdata", 64'(c_rdata[0][0]), 64'hDEAD_BEEF);
        chk("s1_c1_rdata", 64'(c_rdata[0][1]), 64'd0);
        chk("s1_c1_fin", 64'(c_fin[0][1]), 64'd0);
        c_req[0][0] = 1'b0;
        @(negedge clk);
        chk("s1_fin_clear", 64'(c_fin[0][0]), 64'd0);
        force_dly[0] = 0;

        // round-robin alternation with both clients re-requesting
        do_reset(0);
        log_q.delete();
        fork
            for (int k = 0; k < 3; k++) txn(0, 0, 1'b1, 32'h10, 32'h1234_5678);
            for (int k = 0; k < 3; k++) txn(0, 1, 1'b0, 32'h20, 32'h0);
        join
        chk("rr_count", 64'(log_q.size()), 64'd6);
        for (int k = 0; k < 6 && k < log_q.size(); k++) begin
            chk("rr_order", 64'(log_q[k].addr), (k % 2 == 0) ? 64'h10 : 64'h20);
            if (k % 2 == 0) chk("rr_wdata", 64'(log_q[k].data), 64'h1234_5678);
        end

        // tie after a client-0 grant: round-robin picks 1, fixed priority picks 0
        for (int i = 0; i < 2; i++) begin
            do_reset(i);
            txn(i, 0, 1'b0, 32'h100, 32'h0);
            log_q.delete();
            fork
                txn(i, 0, 1'b0, 32'h104, 32'h0);
                txn(i, 1, 1'b0, 32'h204, 32'h0);
            join
            chk("tie_count", 64'(log_q.size()), 64'd2);
            if (log_q.size() > 0)
                chk("tie_winner", 64'(log_q[0].addr), (i == 1) ? 64'h104 : 64'h204);
        end

        // init_fin gating and abort during issue
        do_reset(0);
        log_q.delete();
        force_dly[0] = 8;
        init_fin[0] = 1'b0;
        w = $urandom;
        c_we[0][0] = 1'b1; c_addr[0][0] = 32'h300; c_wdata[0][0] = w; c_req[0][0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("init_low_wr_req", 64'(m_wr_req[0]), 64'd0);
            chk("init_low_busy", 64'(busy[0]), 64'd0);
        end
        init_fin[0] = 1'b1;
        @(negedge clk);
        chk("init_grant", 64'(busy[0]), 64'd1);
        @(negedge clk);
        chk("init_wr_req", 64'(m_wr_req[0]), 64'd1);
        chk("init_wr_data", 64'(m_wr_data[0]), 64'(w));
        repeat (2) @(negedge clk);
        init_fin[0] = 1'b0;
        @(negedge clk);
        chk("abort_wr_req", 64'(m_wr_req[0]), 64'd0);
        chk("abort_busy", 64'(busy[0]), 64'd0);
        chk("abort_no_fin", 64'(c_fin[0][0]), 64'd0);
        chk("abort_no_write", 64'(log_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        chk("abort_held", 64'(m_wr_req[0]), 64'd0);
        init_fin[0] = 1'b1;
        wait_fin(0, 0, got);
        chk("reissue_count", 64'(log_q.size()), 64'd1);
        if (log_q.size() > 0) chk("reissue_data", 64'(log_q[0].data), 64'(w));
        c_req[0][0] = 1'b0;
        @(negedge clk);
        chk("reissue_fin_clear", 64'(c_fin[0][0]), 64'd0);

        // client 1 drops req early; write completes, fin pulses once
        do_reset(0);
        log_q.delete();
        force_dly[0] = 6;
        w = $urandom;
        c_we[0][1] = 1'b1; c_addr[0][1] = 32'h340; c_wdata[0][1] = w; c_req[0][1] = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = m_wr_req[0];
        end
        chk("early_issue", 64'(seen), 64'd1);
        repeat (2) @(negedge clk);
        c_req[0][1] = 1'b0;
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (c_fin[0][1]) pulses++;
        end
        chk("early_fin_pulse", 64'(pulses), 64'd1);
        chk("early_write_done", 64'(log_q.size()), 64'd1);
        if (log_q.size() > 0) chk("early_write_data", 64'(log_q[0].data), 64'(w));
        chk("early_idle", 64'(busy[0]), 64'd0);

        // reset while in RELEASE after a client-0 read
        do_reset(0);
        force_dly[0] = 3;
        c_we[0][0] = 1'b0; c_addr[0][0] = 32'h500; c_req[0][0] = 1'b1;
        seen = 1'b0; got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (m_rd_req[0]) seen = 1'b1;
            got = seen && !m_rd_req[0] && busy[0];
        end
        chk("rel_reached", 64'(got), 64'd1);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("rel_rst_busy", 64'(busy[0]), 64'd0);
        chk("rel_rst_rd_req", 64'(m_rd_req[0]), 64'd0);
        chk("rel_rst_fin", 64'(c_fin[0][0]), 64'd0);
        chk("rel_rst_rdata", 64'(c_rdata[0][0]), 64'd0);
        chk("rel_rst_gid", 64'(gid[0]), 64'd0);
        c_req[0][0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b0;
        force_dly[0] = 0;
        log_q.delete();
        fork
            txn(0, 0, 1'b0, 32'h504, 32'h0);
            txn(0, 1, 1'b0, 32'h604, 32'h0);
        join
        if (log_q.size() > 0) chk("rel_tie_c0", 64'(log_q[0].addr), 64'h504);
        else chk("rel_tie_count", 64'(log_q.size()), 64'd2);

        // random traffic on both arbiters
        for (int i = 0; i < 2; i++) begin
            do_reset(i);
            log_q.delete();
            fork
                rand_client(i, 0);
                rand_client(i, 1);
            join
            chk("rand_count", 64'(log_q.size()), 64'd12);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Two-client arbiter that shares the single SDRAM controller read/write port between requesters, for example CPU data port (client 0) and instruction-fetch/GC port (client 1). Each client uses the same level handshake the controller exposes: hold req until fin, drop req, fin clears. The arbiter latches one client's command, drives the controller, captures read data, and returns completion to that client. Sits directly between the core-side memory clients and the SDRAM controller.

Parameters:
FIXED_PRIO, 0, 0 = round-robin; 1 = client 0 always wins when both are pending
ADDR_W, 32, address width passed to the controller
DATA_W, 32, data width per transaction

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
init_fin  in  1  controller initialisation done; no grants while low
c0_req  in  1  client 0 request (level, held until c0_fin)
c0_we  in  1  client 0 write (1) / read (0)
c0_addr  in  ADDR_W  client 0 address
c0_wdata  in  DATA_W  client 0 write data
c0_fin  out  1  client 0 completion (level)
c0_rdata  out  DATA_W  client 0 read data, valid while c0_fin=1 after a read
c1_req, c1_we, c1_addr, c1_wdata, c1_fin, c1_rdata  same as client 0, for client 1
mem_rd_req  out  1  to controller rd_req
mem_rd_addr  out  ADDR_W  to controller rd_addr
mem_rd_fin  in  1  from controller rd_fin
mem_rd_data  in  DATA_W  from controller rd_data
mem_wr_req  out  1  to controller wr_req
mem_wr_addr  out  ADDR_W  to controller wr_addr
mem_wr_data  out  DATA_W  to controller wr_data
mem_wr_fin  in  1  from controller wr_fin
busy  out  1  transaction in flight (state != IDLE)
grant_id  out  1  client owning the current or last transaction

Behaviour:
- Reset (sync, active-high): state=IDLE; all outputs 0; last_grant=1, so client 0 wins the first tie. Reset mid-transaction drops mem_*_req the next cycle with no client fin.
- Pending(n) = cn_req & ~cn_fin.
- States: IDLE, ISSUE, RELEASE.
- IDLE:
  - Requires init_fin=1 and at least one pending client.
  - Selection: if only one is pending, grant it. If both are pending and FIXED_PRIO=0, grant ~last_grant. If FIXED_PRIO=1, grant client 0.
  - On grant, latch we/addr/wdata of the granted client into internal regs. Set grant_id and last_grant. Go to ISSUE.
  - Later changes on client inputs are ignored for this transaction.
- ISSUE:
  - Assert mem_wr_req (we=1) or mem_rd_req (we=0) from registers. The other req stays 0.
  - Addresses and data are driven from the latched regs.
  - Latency: client req sampled at edge N, mem req is high after edge N+1.
  - When the matching mem_*_fin is sampled 1:
    - For a read, capture mem_rd_data into cn_rdata of the granted client; the other client's rdata is unchanged.
    - Deassert the mem req and go to RELEASE.
- RELEASE:
  - Wait until the matching mem_*_fin is sampled 0 (controller clears fin once req is low).
  - Then set cn_fin=1 for the granted client and go to IDLE.
  - A new grant is possible in the following cycle.
- Client fin rule, each cycle per client: cn_fin <= cn_fin & cn_req, except when set by RELEASE exit.
  - If the client already dropped req, fin stays high for exactly one cycle, then clears.
  - While cn_fin=1 that client is not pending, so no duplicate issue.
- Client dropping req during ISSUE/RELEASE: the memory transaction still completes; the fin rule above applies.
- init_fin falling during ISSUE/RELEASE: abort to IDLE next cycle, deassert mem reqs, no fin, rdata unchanged. The client remains pending and is reissued after init_fin returns.
- mem_rd_req and mem_wr_req are never both 1.
- While in IDLE, mem_wr_data and the addresses hold their last values.
- No timeout; the arbiter waits indefinitely for mem fin.

Test Plan:
- Single read: c0 read addr 0x0000_0400; model returns 0xDEAD_BEEF with rd_fin 5 cycles after rd_req → mem_rd_req high 1 cycle after c0_req; c0_rdata=0xDEAD_BEEF with c0_fin=1; c0_fin clears 1 cycle after c0_req drops; c1 outputs untouched.
- Simultaneous requests, FIXED_PRIO=0: c0 write 0x1234_5678 @0x10 and c1 read @0x20 issued in the same cycle, both re-requesting 3 times → grants alternate 0,1,0,1,0,1; mem_wr_data=0x1234_5678 on each c0 grant.
- FIXED_PRIO=1 with both clients continuously re-requesting → client 0 served every time; client 1 served only in gaps where c0_req is low.
- init_fin low → no mem req despite pending c0_req. init_fin rising → grant within 1 cycle. init_fin dropped during ISSUE → mem req low next cycle, no c0_fin, reissued later.
- Early drop: c1 drops req 2 cycles into ISSUE → write still completes at the model; c1_fin pulses exactly 1 cycle.
- Reset asserted during RELEASE → all outputs 0 next cycle; client 0 wins the next tie.
